// File: rtl/mm_pkg.sv
// Shared constants for the 2x2 matrix-multiply engine: FSM encodings, frame
// headers, and the MAC step decoding used by the scheduler.
package mm_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_MAC  = 2'd2;
    localparam state_t ST_SEND = 2'd3;

    localparam logic [7:0] HDR_CMD = 8'hA5;
    localparam logic [7:0] HDR_RSP = 8'h5A;

    localparam int N_OPERANDS     = 8;
    localparam int N_RESULT_BYTES = 9;
    localparam int N_MAC_STEPS    = 12;

    // Each result element takes three steps: clear+mul, accumulate, capture.
    function automatic logic [1:0] step_elem(input logic [3:0] s);
        return 2'(s / 4'd3);
    endfunction

    function automatic logic [1:0] step_phase(input logic [3:0] s);
        return 2'(s % 4'd3);
    endfunction

endpackage

// File: rtl/mm_mac.sv
// Registered multiply-accumulate shared by the matrix engine requesters.
// clr together with en replaces the accumulator instead of adding to it.
module mm_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] prod;

    always_comb begin
        prod  = ACC_W'(a) * ACC_W'(b);
        acc_d = acc_q;
        if (en) begin
            acc_d = clr ? prod : acc_q + prod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mm_mac_scheduler.sv
// Frame-level controller: parses A5-prefixed operand frames, sequences the
// shared MAC to form C = A x B, and streams the 5A-prefixed reply.
module mm_mac_scheduler
    import mm_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mac_clr,
    output logic              mac_en,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [ACC_W-1:0]  mac_acc,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              err_overrun,
    output logic              err_timeout
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    state_t                           state_q, state_d;
    logic [3:0]                       idx_q, idx_d;
    logic [3:0]                       step_q, step_d;
    logic [3:0]                       tx_cnt_q, tx_cnt_d;
    logic [TO_W-1:0]                  to_cnt_q, to_cnt_d;
    logic [N_OPERANDS-1:0][DATA_W-1:0] opnd_q, opnd_d;
    logic [3:0][ACC_W-1:0]            c_q, c_d;
    logic                             ovr_q, ovr_d;
    logic                             tmo_q, tmo_d;

    logic [1:0]  elem;
    logic [1:0]  phase;
    logic [2:0]  tx_k;
    logic [15:0] tx_word;

    assign elem  = step_elem(step_q);
    assign phase = step_phase(step_q);

    // Operand slots: A[i][k] at {0,i,k}, B[k][j] at {1,k,j}.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        step_d   = step_q;
        tx_cnt_d = tx_cnt_q;
        to_cnt_d = to_cnt_q;
        opnd_d   = opnd_q;
        c_d      = c_q;
        ovr_d    = 1'b0;
        tmo_d    = 1'b0;
        mac_en   = 1'b0;
        mac_clr  = 1'b0;
        mac_a    = '0;
        mac_b    = '0;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid && rx_data == HDR_CMD) begin
                    state_d  = ST_LOAD;
                    idx_d    = 4'd0;
                    to_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                // The cycle after B3 is stored belongs to the compute phase.
                if (idx_q == 4'(N_OPERANDS)) begin
                    state_d = ST_MAC;
                    step_d  = 4'd0;
                    ovr_d   = rx_valid;
                end else if (rx_valid) begin
                    opnd_d[idx_q[2:0]] = DATA_W'(rx_data);
                    idx_d              = idx_q + 4'd1;
                    to_cnt_d           = '0;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYC)) begin
                    state_d  = ST_IDLE;
                    tmo_d    = 1'b1;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_MAC: begin
                ovr_d = rx_valid;
                case (phase)
                    2'd0: begin
                        mac_en  = 1'b1;
                        mac_clr = 1'b1;
                        mac_a   = opnd_q[{1'b0, elem[1], 1'b0}];
                        mac_b   = opnd_q[{1'b1, 1'b0, elem[0]}];
                    end
                    2'd1: begin
                        mac_en = 1'b1;
                        mac_a  = opnd_q[{1'b0, elem[1], 1'b1}];
                        mac_b  = opnd_q[{1'b1, 1'b1, elem[0]}];
                    end
                    default: begin
                        c_d[elem] = mac_acc;
                    end
                endcase
                if (step_q == 4'(N_MAC_STEPS - 1)) begin
                    state_d  = ST_SEND;
                    tx_cnt_d = 4'd0;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            default: begin
                ovr_d = rx_valid;
                if (tx_ready) begin
                    if (tx_cnt_q == 4'(N_RESULT_BYTES - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 4'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            step_q   <= '0;
            tx_cnt_q <= '0;
            to_cnt_q <= '0;
            opnd_q   <= '0;
            c_q      <= '0;
            ovr_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            step_q   <= step_d;
            tx_cnt_q <= tx_cnt_d;
            to_cnt_q <= to_cnt_d;
            opnd_q   <= opnd_d;
            c_q      <= c_d;
            ovr_q    <= ovr_d;
            tmo_q    <= tmo_d;
        end
    end

    // Reply byte n>0 is byte (n-1) of C00..C11, high byte first.
    assign tx_k    = tx_cnt_q[2:0] - 3'd1;
    assign tx_word = 16'(c_q[tx_k[2:1]]);

    always_comb begin
        tx_data = 8'h00;
        if (state_q == ST_SEND) begin
            if (tx_cnt_q == 4'd0) begin
                tx_data = HDR_RSP;
            end else begin
                tx_data = tx_k[0] ? tx_word[7:0] : tx_word[15:8];
            end
        end
    end

    assign tx_valid    = (state_q == ST_SEND);
    assign busy        = (state_q != ST_IDLE);
    assign err_overrun = ovr_q;
    assign err_timeout = tmo_q;

endmodule
